// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// datapath widths, funct3 encodings, FSM states and special-case constants.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DXLEN = 2 * XLEN;
    localparam int unsigned CNT_W = 6;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } core_mode_e;

    // Magnitude of v when it is treated as signed, otherwise v unchanged.
    function automatic logic [XLEN-1:0] magnitude(input logic is_signed, input logic [XLEN-1:0] v);
        return (is_signed && v[XLEN-1]) ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_stall_unit_if.sv
// Pipeline <-> M-unit bundle.
//   master: EX pipeline side (drives instruction, operands, overrides, flush)
//   slave : muldiv unit (drives stall and result)
interface ex_muldiv_stall_unit_if;
    import muldiv_pkg::*;

    logic            ID_EX_muldiv;
    logic [2:0]      ID_EX_funct3;
    logic [XLEN-1:0] EX_rs1_data;
    logic [XLEN-1:0] EX_rs2_data;
    logic [XLEN-1:0] ID_EX_stall_hazard_rs1_data;
    logic [XLEN-1:0] ID_EX_stall_hazard_rs2_data;
    logic            ID_EX_stall_hazard_rs1_data_enable;
    logic            ID_EX_stall_hazard_rs2_data_enable;
    logic            EX_flush;
    logic            EX_stall;
    logic [XLEN-1:0] muldiv_result;
    logic            muldiv_result_valid;

    modport master (
        output ID_EX_muldiv, ID_EX_funct3, EX_rs1_data, EX_rs2_data,
               ID_EX_stall_hazard_rs1_data, ID_EX_stall_hazard_rs2_data,
               ID_EX_stall_hazard_rs1_data_enable, ID_EX_stall_hazard_rs2_data_enable,
               EX_flush,
        input  EX_stall, muldiv_result, muldiv_result_valid
    );

    modport slave (
        input  ID_EX_muldiv, ID_EX_funct3, EX_rs1_data, EX_rs2_data,
               ID_EX_stall_hazard_rs1_data, ID_EX_stall_hazard_rs2_data,
               ID_EX_stall_hazard_rs1_data_enable, ID_EX_stall_hazard_rs2_data_enable,
               EX_flush,
        output EX_stall, muldiv_result, muldiv_result_valid
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// Shared 64-bit accumulator with one radix-2 iteration per step.
//   mul: {hi,lo} = {0, multiplier}; add multiplicand to hi when lo[0], shift right.
//   div: {hi,lo} = {0, dividend}; shift left, restoring subtract, quotient bit into lo[0].
// Ports: clk, rst_n, load (init from op_a/op_b), step (advance one bit),
//        mode, op_a (multiplier/dividend), op_b (multiplicand/divisor),
//        acc_next (accumulator value after the current step).
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  core_mode_e       mode,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic [DXLEN-1:0] acc_next
);

    logic [DXLEN-1:0] acc;
    logic [XLEN-1:0]  b_q;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_hi;
    logic [XLEN:0]    div_diff;

    // One iteration; the 33-bit hi paths keep the carry / shifted-out remainder bit.
    always_comb begin
        mul_sum  = {1'b0, acc[DXLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        div_hi   = acc[DXLEN-1:XLEN-1];
        div_diff = div_hi - {1'b0, b_q};
        if (mode == MODE_MUL) begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {div_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            b_q <= '0;
        end else if (load) begin
            acc <= {XLEN'(0), op_a};
            b_q <= op_b;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/ex_muldiv_stall_unit.sv
// RV32M execute unit beside the ALU: stalls IF/ID/EX while iterating, takes
// late operand overrides in LOAD, and presents the result in the DONE cycle.
// Ports: clk, rst_n, bus (slave side of ex_muldiv_stall_unit_if).
module ex_muldiv_stall_unit
    import muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    ex_muldiv_stall_unit_if.slave bus
);

    state_e           state, state_next;
    funct3_e          f3_q;
    logic [XLEN-1:0]  rs1_q, rs2_q, result_q;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;

    logic stall_c, valid_c, latch_en, core_load, core_step, res_we, res_special;

    logic [XLEN-1:0]  op1, op2, mag1, mag2, special_res, final_res, q_fix, r_fix;
    logic [DXLEN-1:0] acc_next, prod_fix;
    logic             sgn1, sgn2, is_div, is_rem, neg_ld, special;

    // LOAD-cycle decode: overrides, signedness, magnitudes, special cases.
    always_comb begin
        op1    = bus.ID_EX_stall_hazard_rs1_data_enable ? bus.ID_EX_stall_hazard_rs1_data : rs1_q;
        op2    = bus.ID_EX_stall_hazard_rs2_data_enable ? bus.ID_EX_stall_hazard_rs2_data : rs2_q;
        is_div = f3_q[2];
        is_rem = f3_q[2] & f3_q[1];
        sgn1   = f3_q inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        sgn2   = f3_q inside {F3_MULH, F3_DIV, F3_REM};
        mag1   = magnitude(sgn1, op1);
        mag2   = magnitude(sgn2, op2);
        // Remainder follows the dividend; everything else is the xor of operand signs.
        neg_ld = is_rem ? (sgn1 & op1[XLEN-1])
                        : ((sgn1 & op1[XLEN-1]) ^ (sgn2 & op2[XLEN-1]));
        special = is_div && ((op2 == '0) || (sgn1 && (op1 == INT_MIN) && (op2 == '1)));
        if (op2 == '0) begin
            special_res = is_rem ? op1 : DIV_ZERO_Q;
        end else begin
            special_res = is_rem ? '0 : INT_MIN;
        end
    end

    // Sign fix and word select on the final iteration's accumulator.
    always_comb begin
        prod_fix = neg_q ? DXLEN'(-acc_next) : acc_next;
        q_fix    = neg_q ? XLEN'(-acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
        r_fix    = neg_q ? XLEN'(-acc_next[DXLEN-1:XLEN]) : acc_next[DXLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                       final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[DXLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_res = q_fix;
            default:                      final_res = r_fix;
        endcase
    end

    muldiv_iter_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .mode     (f3_q[2] ? MODE_DIV : MODE_MUL),
        .op_a     (mag1),
        .op_b     (mag2),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and control; stall drops in the DONE and flush cycles.
    always_comb begin
        state_next  = state;
        stall_c     = 1'b0;
        valid_c     = 1'b0;
        latch_en    = 1'b0;
        core_load   = 1'b0;
        core_step   = 1'b0;
        res_we      = 1'b0;
        res_special = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ID_EX_muldiv && !bus.EX_flush) begin
                    stall_c    = 1'b1;
                    latch_en   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (bus.EX_flush) begin
                    state_next = IDLE;
                end else if (special) begin
                    stall_c     = 1'b1;
                    res_we      = 1'b1;
                    res_special = 1'b1;
                    state_next  = DONE;
                end else begin
                    stall_c    = 1'b1;
                    core_load  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.EX_flush) begin
                    state_next = IDLE;
                end else begin
                    stall_c   = 1'b1;
                    core_step = 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        res_we     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: begin
                valid_c    = !bus.EX_flush;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q     <= F3_MUL;
            rs1_q    <= '0;
            rs2_q    <= '0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            if (latch_en) begin
                f3_q  <= funct3_e'(bus.ID_EX_funct3);
                rs1_q <= bus.EX_rs1_data;
                rs2_q <= bus.EX_rs2_data;
            end
            if (core_load) begin
                neg_q <= neg_ld;
                cnt   <= '0;
            end
            if (core_step) cnt <= cnt + CNT_W'(1);
            if (res_we) result_q <= res_special ? special_res : final_res;
        end
    end

    assign bus.EX_stall            = stall_c;
    assign bus.muldiv_result_valid = valid_c;
    assign bus.muldiv_result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_stall_unit.sv
// Self-checking bench for ex_muldiv_stall_unit: directed RV32M cases, hazard
// overrides, flush, reset, back-to-back and random ops against a reference model.
module tb_ex_muldiv_stall_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_stall_unit_if bus();

    ex_muldiv_stall_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: RV32M semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] qa, qb, qr;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        qa = a;
        qb = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                qr = qa / qb; return qr;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                qr = qa % qb; return qr;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return 34;
    endfunction

    task automatic drive_idle();
        bus.ID_EX_muldiv = 1'b0;
        bus.ID_EX_funct3 = 3'd0;
        bus.EX_rs1_data = 32'd0;
        bus.EX_rs2_data = 32'd0;
        bus.ID_EX_stall_hazard_rs1_data = 32'd0;
        bus.ID_EX_stall_hazard_rs2_data = 32'd0;
        bus.ID_EX_stall_hazard_rs1_data_enable = 1'b0;
        bus.ID_EX_stall_hazard_rs2_data_enable = 1'b0;
        bus.EX_flush = 1'b0;
    endtask

    // Issue one op and observe it; cycle 0 is the issue cycle. hz_cycle selects
    // the cycle in which the override enables (hz_mask) are raised.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input int hz_cycle, input logic [1:0] hz_mask,
                            input logic [31:0] hz1, input logic [31:0] hz2,
                            input bit skip_sync, input bit chain,
                            output logic [31:0] res, output int stall_n,
                            output int done_cyc, output int pulses);
        stall_n = 0; done_cyc = -1; pulses = 0; res = 32'd0;
        if (!skip_sync) begin @(posedge clk); #1; end
        bus.ID_EX_muldiv = 1'b1;
        bus.ID_EX_funct3 = f3;
        bus.EX_rs1_data = a;
        bus.EX_rs2_data = b;
        bus.ID_EX_stall_hazard_rs1_data = hz1;
        bus.ID_EX_stall_hazard_rs2_data = hz2;
        for (int c = 0; c < 60; c++) begin
            bus.ID_EX_stall_hazard_rs1_data_enable = (c == hz_cycle) && hz_mask[0];
            bus.ID_EX_stall_hazard_rs2_data_enable = (c == hz_cycle) && hz_mask[1];
            @(negedge clk);
            if (bus.EX_stall) stall_n++;
            if (bus.muldiv_result_valid) begin
                pulses++;
                if (done_cyc < 0) begin done_cyc = c; res = bus.muldiv_result; end
            end
            @(posedge clk); #1;
            if (done_cyc >= 0) begin
                if (chain) break;
                if (c == done_cyc) bus.ID_EX_muldiv = 1'b0;
                if (c >= done_cyc + 2) break;
            end
        end
        if (!chain) bus.ID_EX_muldiv = 1'b0;
        bus.ID_EX_stall_hazard_rs1_data_enable = 1'b0;
        bus.ID_EX_stall_hazard_rs2_data_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #12;
        checks++; if (bus.EX_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.EX_stall); end
        checks++; if (bus.muldiv_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.muldiv_result); end
        checks++; if (bus.muldiv_result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.muldiv_result_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.EX_stall !== 1'b0 || bus.muldiv_result_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got stall=%b valid=%b want 0 0", bus.EX_stall, bus.muldiv_result_valid);
        end
    endtask

    logic [2:0]  dir_f3  [10] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd7, 3'd1};
    logic [31:0] dir_a   [10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd5, 32'h80000000, 32'h80000000, 32'd9, 32'h80000000};
    logic [31:0] dir_b   [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                                  32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    logic [31:0] dir_exp [10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd9, 32'h40000000};
    int          dir_lat [10] = '{34, 34, 34, 34, 34, 2, 2, 2, 2, 34};

    task automatic test_directed();
        logic [31:0] res; int st, dc, pl;
        for (int i = 0; i < 10; i++) begin
            issue_op(dir_f3[i], dir_a[i], dir_b[i], -1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
            checks++; if (res !== dir_exp[i]) begin errors++; $display("FAIL directed_%0d_result got %h want %h", i, res, dir_exp[i]); end
            checks++; if (dc != dir_lat[i]) begin errors++; $display("FAIL directed_%0d_latency got %0d want %0d", i, dc, dir_lat[i]); end
            checks++; if (st != dir_lat[i]) begin errors++; $display("FAIL directed_%0d_stall_cycles got %0d want %0d", i, st, dir_lat[i]); end
            checks++; if (pl != 1) begin errors++; $display("FAIL directed_%0d_valid_pulses got %0d want 1", i, pl); end
        end
    endtask

    task automatic test_hazard();
        logic [31:0] res; int st, dc, pl;
        issue_op(3'd5, 32'd100, 32'd4, 1, 2'b01, 32'd40, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'd10) begin errors++; $display("FAIL hazard_load_rs1 got %0d want 10", res); end
        issue_op(3'd5, 32'd100, 32'd4, 5, 2'b01, 32'd40, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'd25) begin errors++; $display("FAIL hazard_busy_ignored got %0d want 25", res); end
        issue_op(3'd5, 32'd100, 32'd4, 0, 2'b01, 32'd40, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'd25) begin errors++; $display("FAIL hazard_issue_ignored got %0d want 25", res); end
        issue_op(3'd0, 32'd6, 32'd7, 1, 2'b10, 32'd0, 32'd10, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'd60) begin errors++; $display("FAIL hazard_load_rs2 got %0d want 60", res); end
        // Override turning a divide into a divide-by-zero takes the short path.
        issue_op(3'd4, 32'd50, 32'd5, 1, 2'b10, 32'd0, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'hFFFFFFFF || dc != 2) begin
            errors++; $display("FAIL hazard_div_zero got %h lat %0d want ffffffff lat 2", res, dc);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res; int st, dc, pl, vcount, stall_bad;
        logic stall_at_flush;
        vcount = 0; stall_bad = 0; stall_at_flush = 1'b1;
        @(posedge clk); #1;
        bus.ID_EX_muldiv = 1'b1; bus.ID_EX_funct3 = 3'd0; bus.EX_rs1_data = 32'd5; bus.EX_rs2_data = 32'd5;
        for (int c = 0; c <= 10; c++) begin
            bus.EX_flush = (c == 10);
            @(negedge clk);
            if (bus.muldiv_result_valid) vcount++;
            if (c < 10 && !bus.EX_stall) stall_bad++;
            if (c == 10) stall_at_flush = bus.EX_stall;
            @(posedge clk); #1;
        end
        bus.EX_flush = 1'b0; bus.ID_EX_muldiv = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.muldiv_result_valid || bus.EX_stall) vcount++;
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL flush_stall_before got %0d low cycles want 0", stall_bad); end
        checks++; if (stall_at_flush !== 1'b0) begin errors++; $display("FAIL flush_stall_drop got %b want 0", stall_at_flush); end
        checks++; if (vcount != 0) begin errors++; $display("FAIL flush_no_valid got %0d activity cycles want 0", vcount); end
        issue_op(3'd0, 32'd3, 32'd3, -1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'd9 || dc != 34) begin errors++; $display("FAIL flush_then_mul got %0d lat %0d want 9 lat 34", res, dc); end

        // Flush landing on the DONE cycle suppresses the pulse.
        vcount = 0; stall_bad = 0;
        @(posedge clk); #1;
        bus.ID_EX_muldiv = 1'b1; bus.ID_EX_funct3 = 3'd4; bus.EX_rs1_data = 32'd20; bus.EX_rs2_data = 32'd3;
        for (int c = 0; c <= 34; c++) begin
            bus.EX_flush = (c == 34);
            @(negedge clk);
            if (bus.muldiv_result_valid) vcount++;
            if (c < 34 && !bus.EX_stall) stall_bad++;
            if (c == 34 && bus.EX_stall) stall_bad++;
            @(posedge clk); #1;
        end
        bus.EX_flush = 1'b0; bus.ID_EX_muldiv = 1'b0;
        checks++; if (vcount != 0) begin errors++; $display("FAIL flush_done_valid got %0d pulses want 0", vcount); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL flush_done_stall got %0d bad cycles want 0", stall_bad); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res; int st, dc, pl;
        issue_op(3'd0, 32'd3, 32'd3, -1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        repeat (3) @(negedge clk);
        checks++; if (bus.muldiv_result !== 32'd9) begin errors++; $display("FAIL result_hold got %0d want 9", bus.muldiv_result); end
        @(posedge clk); #1;
        bus.ID_EX_muldiv = 1'b1; bus.ID_EX_funct3 = 3'd0; bus.EX_rs1_data = 32'h1234; bus.EX_rs2_data = 32'h10;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0; bus.ID_EX_muldiv = 1'b0;
        #1;
        checks++; if (bus.EX_stall !== 1'b0 || bus.muldiv_result !== 32'd0 || bus.muldiv_result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_midop got stall=%b result=%h valid=%b want 0 0 0",
                               bus.EX_stall, bus.muldiv_result, bus.muldiv_result_valid);
        end
        #2 rst_n = 1'b1;
        issue_op(3'd3, 32'h0001_0000, 32'h0003_0000, -1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
        checks++; if (res !== 32'd3 || dc != 34) begin errors++; $display("FAIL after_reset_op got %h lat %0d want 3 lat 34", res, dc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res_a, res_b; int st_a, dc_a, pl_a, st_b, dc_b, pl_b;
        issue_op(3'd5, 32'd1000, 32'd7, -1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, res_a, st_a, dc_a, pl_a);
        issue_op(3'd7, 32'd1000, 32'd7, -1, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, res_b, st_b, dc_b, pl_b);
        checks++; if (res_a !== 32'd142 || dc_a != 34) begin errors++; $display("FAIL b2b_first got %0d lat %0d want 142 lat 34", res_a, dc_a); end
        checks++; if (res_b !== 32'd6 || dc_b != 34 || pl_b != 1) begin
            errors++; $display("FAIL b2b_second got %0d lat %0d pulses %0d want 6 lat 34 pulses 1", res_b, dc_b, pl_b);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp; logic [2:0] f3; int st, dc, pl, lat, sel, t;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            a = $urandom; b = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel <= 3) begin
                t = int'($urandom_range(0, 40)) - 20; a = 32'(t);
                t = int'($urandom_range(0, 16)) - 8;  b = 32'(t);
            end
            exp = ref_model(f3, a, b);
            lat = ref_latency(f3, a, b);
            issue_op(f3, a, b, -1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, res, st, dc, pl);
            checks++; if (res !== exp) begin errors++; $display("FAIL random_%0d f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, res, exp); end
            checks++; if (dc != lat || st != lat || pl != 1) begin
                errors++; $display("FAIL random_%0d_timing got lat %0d stall %0d pulses %0d want %0d %0d 1", i, dc, st, pl, lat, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hazard();
        test_flush();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_stall_unit.md
# ex_muldiv_stall_unit

Multi-cycle RV32M execute unit that sits beside the ALU in EX. It generates `EX_stall` to freeze IF/ID/EX while it computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively. During the stall it takes operand overrides from the EX-stall hazard checker, then presents a 32-bit result in the single cycle the stall drops.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ID_EX_muldiv` in 1: EX holds a valid RV32M instruction (opcode 0110011, funct7 0000001).
- `ID_EX_funct3` in 3: M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `EX_rs1_data`, `EX_rs2_data` in 32: forwarding-resolved operands entering the ALU.
- `ID_EX_stall_hazard_rs1_data`, `ID_EX_stall_hazard_rs2_data` in 32: late-forwarded operand values.
- `ID_EX_stall_hazard_rs1_data_enable`, `ID_EX_stall_hazard_rs2_data_enable` in 1: override valid.
- `EX_flush` in 1: kill the EX instruction (branch/trap).
- `EX_stall` out 1: freeze upstream stages and hold the ID/EX register.
- `muldiv_result` out 32: result; valid only when `muldiv_result_valid`.
- `muldiv_result_valid` out 1: one-cycle pulse; EX_MEM latches `muldiv_result` instead of the ALU result.

## Operation
- FSM states: IDLE, LOAD, BUSY, DONE.
- IDLE: if `ID_EX_muldiv && !EX_flush`, latch funct3 and both operands from `EX_rs*_data`, then go to LOAD.
- LOAD, exactly 1 cycle:
  - Each operand whose hazard enable is 1 is replaced by the hazard data.
  - Signedness is decoded: MULH has both operands signed, MULHSU has rs1 signed only, DIV/REM are signed, the rest are unsigned.
  - Magnitudes and the result sign are formed.
  - Special cases go directly to DONE:
    - Divide by zero: quotient = 0xFFFFFFFF; remainder = rs1.
    - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
  - Otherwise the 6-bit counter is set to 0 and the FSM goes to BUSY.
- BUSY, 32 cycles, counter 0..31:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring division, 1 quotient bit per cycle.
  - Leaves for DONE when the counter reaches 31.
- DONE, 1 cycle:
  - Applies the sign fix (two's-complement negate when needed).
  - Selects the low word for MUL, the high word for MULH*, the quotient for DIV*, or the remainder for REM*.
  - Asserts `muldiv_result_valid`, then returns to IDLE.
  - Remainder takes the sign of the dividend; quotient is negative iff operand signs differ and the divisor is nonzero.
- `EX_stall` is combinational:
  - 1 in IDLE when `ID_EX_muldiv && !EX_flush`, and in LOAD and BUSY.
  - 0 in DONE, so the pipeline advances in the same cycle the result is taken.
- `EX_flush` in LOAD or BUSY aborts to IDLE on the next edge. No `muldiv_result_valid` is produced, and `EX_stall` drops in the flush cycle.
- `EX_flush` in DONE suppresses `muldiv_result_valid`.
- A back-to-back M-op (a new `ID_EX_muldiv` in the cycle after DONE) starts normally from IDLE.

## Timing
- Reset values: state IDLE, counter 0, all datapath registers 0, `EX_stall` 0 (given `ID_EX_muldiv` = 0), `muldiv_result` 0, `muldiv_result_valid` 0.
- Normal op: issue at cycle T, LOAD at T+1, BUSY T+2..T+33, DONE at T+34.
  - `EX_stall` is high T..T+33 (34 cycles).
  - `muldiv_result_valid` is high at T+34.
- Special-case divide: LOAD at T+1, DONE at T+2; `EX_stall` is high T..T+1.
- Hazard overrides are sampled only in LOAD. Enables in any other cycle are ignored.
- `rst_n` low at any time forces the reset values immediately; the in-flight op is lost.
- `muldiv_result` holds its last value outside DONE.

## Structure
- Shared package `muldiv_pkg`: funct3 encodings, FSM state enum, `DIV_ZERO_Q = 32'hFFFFFFFF`, `INT_MIN = 32'h80000000`.
- One sub-module, `muldiv_iter_core`: a 64-bit accumulator/remainder plus an iteration step shared by multiply and divide, with a `mode` input (mul/div).
- The FSM, sign handling and stall logic stay in the top module.

## Test plan
- MUL 7 × −3 with no hazards → `EX_stall` high 34 cycles; then `muldiv_result` = 0xFFFFFFEB with `muldiv_result_valid` for 1 cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE at T+34.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF.
- DIVU 5 / 0 → 0xFFFFFFFF at T+2 with a 2-cycle stall.
- REM 0x80000000 / 0xFFFFFFFF → 0 at T+2.
- DIVU with `EX_rs1_data` = 100 and `ID_EX_stall_hazard_rs1_data_enable` = 1 with data 40 in LOAD, rs2 = 4 → 10.
  - The same enable asserted in BUSY instead gives 25.
- `EX_flush` at T+10 → `EX_stall` low at T+10, no valid pulse, IDLE at T+11.
  - A following MUL 3 × 3 gives 9.
- `rst_n` low at T+20 → all outputs 0 immediately; after release, IDLE accepts a new op.
